// File: rtl/cpu_output_uart.sv
// -----------------------------------------------------------------------------
// cpu_output_uart
//   Buffers words from the CPU write-back output port in a small FIFO and
//   serializes each word as 8N1 UART bytes, low byte first, on one tx line.
//   The CPU cannot be stalled, so a word offered while the FIFO is full is
//   dropped and reported through a sticky overflow flag.
//
// Ports
//   i_clock     system clock, rising edge
//   i_reset     synchronous active-high reset
//   i_outFlag   CPU output strobe, one word offered per cycle while high
//   i_out       CPU output word, sampled only when i_outFlag=1
//   o_tx        UART serial line, idles high
//   o_full      FIFO holds DEPTH words
//   o_empty     FIFO holds no words
//   o_count     number of words currently buffered
//   o_overflow  sticky, a word was dropped since reset
// -----------------------------------------------------------------------------
module cpu_output_uart #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int CLKSPERBIT = 434
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_outFlag,
    input  logic [WIDTH-1:0]         i_out,
    output logic                     o_tx,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int BYTES = WIDTH / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int BW    = (CLKSPERBIT > 1) ? $clog2(CLKSPERBIT) : 1;
    localparam int YW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKSPERBIT - 1);
    localparam logic [YW-1:0] BYTE_LAST = YW'(BYTES - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;

    state_t           r_state;
    logic             r_tx;
    logic [BW-1:0]    r_baud;
    logic [2:0]       r_bit_idx;
    logic [YW-1:0]    r_byte_idx;
    logic [WIDTH-1:0] r_shift;

    logic             w_wr_en;
    logic             w_pop;
    logic             w_bit_end;
    logic [CW-1:0]    w_count_next;

    // Write acceptance uses the registered full flag, so a pop in the same
    // cycle never rescues a write into a full FIFO.
    assign w_wr_en   = i_outFlag & ~r_full;
    assign w_pop     = (r_state == S_IDLE) & ~r_empty;
    assign w_bit_end = (r_baud == BAUD_LAST);

    // Occupancy after this edge; write+pop together leaves it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_wr_en, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage; contents need no reset because pointers gate every read.
    always_ff @(posedge i_clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_out;
        end
    end

    // FIFO pointers, occupancy flags and sticky overflow.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (i_outFlag && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == COUNT_MAX);
            r_empty <= (w_count_next == {CW{1'b0}});
        end
    end

    // Serializer FSM. The tx register takes the level belonging to the state
    // held before the edge, so the line only moves on state entry or at bit
    // boundaries. Data bits are taken from r_shift[0] and the register shifts
    // right once per bit, so the next byte is already in place after 8 bits.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_baud     <= {BW{1'b0}};
            r_bit_idx  <= 3'd0;
            r_byte_idx <= {YW{1'b0}};
            r_shift    <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift    <= r_mem[r_rd_ptr];
                        r_byte_idx <= {YW{1'b0}};
                        r_baud     <= {BW{1'b0}};
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_bit_end) begin
                        r_baud    <= {BW{1'b0}};
                        r_bit_idx <= 3'd0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_bit_end) begin
                        r_baud  <= {BW{1'b0}};
                        r_shift <= {1'b0, r_shift[WIDTH-1:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_baud <= {BW{1'b0}};
                        if (r_byte_idx == BYTE_LAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + YW'(1);
                            r_state    <= S_START;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_baud  <= {BW{1'b0}};
                end
            endcase
        end
    end

    assign o_tx       = r_tx;
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
